// File: rtl/smmha_tcdm_bridge_pkg.sv
// rtl/smmha_tcdm_bridge_pkg.sv - shared types and defaults for the TCDM bridge
// Purpose: request payload carried through the per-port FIFOs, plus the
//          default FIFO depth and outstanding-read limit.
// Ports:   none (package).
package smmha_package;

   // One engine request as stored in the FIFO; wen=1 is a read.
   typedef struct packed {
      logic [31:0] add;
      logic [31:0] data;
      logic [3:0]  be;
      logic        wen;
   } smmha_req_t;

   localparam int SMMHA_DEPTH_DEF     = 4;
   localparam int SMMHA_MAX_OUTST_DEF = 2;

endpackage

// File: rtl/smmha_tcdm_bridge_if.sv
// rtl/smmha_tcdm_bridge_if.sv - MP-wide TCDM request/response bus
// Purpose: groups the per-port request and response signals of one TCDM-style
//          bus. The bridge is the slave on the engine side and the master on
//          the memory side.
// Signals: req/wen/add/data/be (master->slave), gnt/r_data/r_valid (slave->master).
interface smmha_tcdm_bridge_if #(
   parameter int MP = 2
);
   logic [MP-1:0]       req;
   logic [MP-1:0]       wen;
   logic [MP-1:0][31:0] add;
   logic [MP-1:0][31:0] data;
   logic [MP-1:0][3:0]  be;
   logic [MP-1:0]       gnt;
   logic [MP-1:0][31:0] r_data;
   logic [MP-1:0]       r_valid;

   modport master (
      output req, wen, add, data, be,
      input  gnt, r_data, r_valid
   );

   modport slave (
      input  req, wen, add, data, be,
      output gnt, r_data, r_valid
   );
endinterface

// File: rtl/smmha_tcdm_fifo.sv
// rtl/smmha_tcdm_fifo.sv - request FIFO for one bridge port
// Purpose: DEPTH-entry FIFO of smmha_req_t with synchronous flush. Pointers
//          carry one extra MSB so full and empty are distinguished without a
//          separate counter. Output is the registered head, never the input.
// Ports:   clk_i, rst_i, clear_i; push_i/data_i (write side, ignored when full
//          or clearing); pop_i/data_o (read side, ignored when empty);
//          full_o, empty_o status.
module smmha_tcdm_fifo
   import smmha_package::*;
#(
   parameter int DEPTH = SMMHA_DEPTH_DEF
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       clear_i,
   input  logic       push_i,
   input  smmha_req_t data_i,
   input  logic       pop_i,
   output smmha_req_t data_o,
   output logic       full_o,
   output logic       empty_o
);
   localparam int AW = $clog2(DEPTH);

   smmha_req_t  r_mem [DEPTH];
   logic [AW:0] r_wptr;
   logic [AW:0] r_rptr;
   logic        w_push;
   logic        w_pop;

   assign empty_o = (r_wptr == r_rptr);
   assign full_o  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_push  = push_i & ~full_o & ~clear_i;
   assign w_pop   = pop_i & ~empty_o;
   assign data_o  = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk_i) begin
      if (w_push) r_mem[r_wptr[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/smmha_tcdm_bridge.sv
// rtl/smmha_tcdm_bridge.sv - per-port buffered bridge from engine to TCDM
// Purpose: each of MP independent ports buffers engine requests in a FIFO,
//          forwards them to TCDM with at least one cycle of latency, limits
//          in-flight reads to MAX_OUTST and passes read responses straight
//          back. A response with nothing outstanding sets a sticky err_o bit.
// Ports:   clk_i, rst_i (sync, active-high), clear_i (FIFO flush);
//          in_bus   - engine side (slave modport);
//          tcdm_bus - memory side (master modport);
//          err_o    - sticky response-underflow flag per port;
//          stall_cnt_o - per-port count of cycles with req high and gnt low.
// Config:  SMMHA_BRIDGE_PERF_EN enables the stall counters; otherwise
//          stall_cnt_o is constant zero.
module smmha_tcdm_bridge
   import smmha_package::*;
#(
   parameter int MP        = 2,
   parameter int DEPTH     = SMMHA_DEPTH_DEF,
   parameter int MAX_OUTST = SMMHA_MAX_OUTST_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   smmha_tcdm_bridge_if.slave  in_bus,
   smmha_tcdm_bridge_if.master tcdm_bus,
   output logic [MP-1:0]       err_o,
   output logic [MP-1:0][31:0] stall_cnt_o
);
   localparam int OW = $clog2(MAX_OUTST + 1);

   for (genvar gi = 0; gi < MP; gi++) begin : g_port
      smmha_req_t    w_push_data;
      smmha_req_t    w_head;
      logic          w_full;
      logic          w_empty;
      logic          w_push;
      logic          w_pop;
      logic          w_rd_gnt;
      logic          w_rv;
      logic          w_treq;
      logic [OW-1:0] r_outst;
      logic          r_err;

      assign w_push_data = '{add:  in_bus.add[gi],
                             data: in_bus.data[gi],
                             be:   in_bus.be[gi],
                             wen:  in_bus.wen[gi]};

      // Grant is withheld during a flush so the engine never sees a push
      // acknowledged that the flush then throws away.
      assign in_bus.gnt[gi] = ~w_full & ~clear_i;
      assign w_push         = in_bus.req[gi] & ~w_full & ~clear_i;

      // Writes never wait on the read budget; only a read head is throttled.
      assign w_treq   = ~w_empty & (~w_head.wen | (r_outst < OW'(MAX_OUTST)));
      assign w_pop    = w_treq & tcdm_bus.gnt[gi];
      assign w_rd_gnt = w_pop & w_head.wen;
      assign w_rv     = tcdm_bus.r_valid[gi];

      assign tcdm_bus.req[gi]  = w_treq;
      assign tcdm_bus.wen[gi]  = w_head.wen;
      assign tcdm_bus.add[gi]  = w_head.add;
      assign tcdm_bus.data[gi] = w_head.data;
      assign tcdm_bus.be[gi]   = w_head.be;

      assign in_bus.r_data[gi]  = tcdm_bus.r_data[gi];
      assign in_bus.r_valid[gi] = w_rv;

      smmha_tcdm_fifo #(
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .clear_i (clear_i),
         .push_i  (w_push),
         .data_i  (w_push_data),
         .pop_i   (w_pop),
         .data_o  (w_head),
         .full_o  (w_full),
         .empty_o (w_empty)
      );

      // Outstanding reads survive clear_i so responses already in flight are
      // still accounted for; a response with none outstanding is an underflow.
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_outst <= '0;
            r_err   <= 1'b0;
         end else begin
            case ({w_rd_gnt, w_rv})
               2'b10: r_outst <= r_outst + OW'(1);
               2'b01: begin
                  if (r_outst == '0) r_err <= 1'b1;
                  else               r_outst <= r_outst - OW'(1);
               end
               default: ;
            endcase
         end
      end

      assign err_o[gi] = r_err;

`ifdef SMMHA_BRIDGE_PERF_EN
      logic [31:0] r_stall;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_stall <= '0;
         end else if (w_treq && !tcdm_bus.gnt[gi] && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
         end
      end

      assign stall_cnt_o[gi] = r_stall;
`else
      assign stall_cnt_o[gi] = '0;
`endif
   end

endmodule

// File: tb/tb_smmha_tcdm_bridge.sv
// tb/tb_smmha_tcdm_bridge.sv - scoreboard bench for smmha_tcdm_bridge
module tb_smmha_tcdm_bridge;
   import smmha_package::*;

   localparam int MP = 2;

   logic clk = 1'b0;
   logic rst;
   logic clear;
   logic mon_en = 1'b0;
   logic [MP-1:0]       err;
   logic [MP-1:0][31:0] stall;

   int n_chk = 0;
   int n_err = 0;

   smmha_req_t  exp_q [MP][$];
   logic [31:0] rsp_q [MP][$];

`ifdef SMMHA_BRIDGE_PERF_EN
   localparam logic [31:0] EXP_STALL = 32'd10;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
`endif

   always #5 clk = ~clk;

   smmha_tcdm_bridge_if #(.MP(MP)) in_bus ();
   smmha_tcdm_bridge_if #(.MP(MP)) tcdm_bus ();

   smmha_tcdm_bridge #(
      .MP        (MP),
      .DEPTH     (4),
      .MAX_OUTST (2)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .clear_i     (clear),
      .in_bus      (in_bus),
      .tcdm_bus    (tcdm_bus),
      .err_o       (err),
      .stall_cnt_o (stall)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every granted TCDM request and every response to the engine is
   // popped against what the stimulus queued.
   always @(negedge clk) begin : mon
      smmha_req_t e;
      if (mon_en) begin
         for (int p = 0; p < MP; p++) begin
            if (tcdm_bus.req[p] === 1'b1 && tcdm_bus.gnt[p] === 1'b1) begin
               if (exp_q[p].size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL req_issue_p%0d: unexpected request add=%h expected none",
                           p, tcdm_bus.add[p]);
               end else begin
                  e = exp_q[p].pop_front();
                  chk($sformatf("req_add_p%0d", p),  tcdm_bus.add[p],  e.add);
                  chk($sformatf("req_data_p%0d", p), tcdm_bus.data[p], e.data);
                  chk($sformatf("req_be_p%0d", p),   {28'd0, tcdm_bus.be[p]}, {28'd0, e.be});
                  chk($sformatf("req_wen_p%0d", p),  {31'd0, tcdm_bus.wen[p]}, {31'd0, e.wen});
               end
            end
            if (in_bus.r_valid[p] === 1'b1) begin
               if (rsp_q[p].size() == 0) begin
                  n_chk++;
                  n_err++;
                  $display("FAIL rsp_p%0d: unexpected response %h expected none",
                           p, in_bus.r_data[p]);
               end else begin
                  chk($sformatf("rsp_data_p%0d", p), in_bus.r_data[p], rsp_q[p].pop_front());
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      for (int p = 0; p < MP; p++) exp_q[p].delete();
   endtask

   task automatic push(input int p, input logic a_wen, input logic [31:0] a_add,
                       input logic [31:0] a_data, input logic [3:0] a_be);
      int waited = 0;
      in_bus.req[p]  = 1'b1;
      in_bus.wen[p]  = a_wen;
      in_bus.add[p]  = a_add;
      in_bus.data[p] = a_data;
      in_bus.be[p]   = a_be;
      @(negedge clk);
      while (in_bus.gnt[p] !== 1'b1 && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      if (in_bus.gnt[p] !== 1'b1) begin
         chk($sformatf("push_gnt_timeout_p%0d", p), {31'd0, in_bus.gnt[p]}, 32'd1);
      end else begin
         exp_q[p].push_back('{add: a_add, data: a_data, be: a_be, wen: a_wen});
         @(posedge clk);
         #1;
      end
      in_bus.req[p] = 1'b0;
   endtask

   task automatic respond(input int p, input logic [31:0] d);
      tcdm_bus.r_valid[p] = 1'b1;
      tcdm_bus.r_data[p]  = d;
      rsp_q[p].push_back(d);
      tick();
      tcdm_bus.r_valid[p] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst   = 1'b1;
      clear = 1'b0;
      in_bus.req  = '0;
      in_bus.wen  = '0;
      in_bus.add  = '0;
      in_bus.data = '0;
      in_bus.be   = '0;
      tcdm_bus.gnt     = '1;
      tcdm_bus.r_valid = '0;
      tcdm_bus.r_data  = '0;

      // Reset state
      do_reset();
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_in_gnt",   {30'd0, in_bus.gnt}, 32'd3);
      chk("rst_tcdm_req", {30'd0, tcdm_bus.req}, 32'd0);
      chk("rst_err",      {30'd0, err}, 32'd0);
      chk("rst_stall0",   stall[0], 32'd0);
      chk("rst_stall1",   stall[1], 32'd0);

      // Single read, one-cycle latency, response passed through
      tick();
      in_bus.req[0] = 1'b1;
      in_bus.wen[0] = 1'b1;
      in_bus.add[0] = 32'h0000_1000;
      in_bus.data[0] = 32'h0;
      in_bus.be[0] = 4'hF;
      @(negedge clk);
      chk("no_bypass", {31'd0, tcdm_bus.req[0]}, 32'd0);
      chk("single_gnt", {31'd0, in_bus.gnt[0]}, 32'd1);
      exp_q[0].push_back('{add: 32'h0000_1000, data: 32'h0, be: 4'hF, wen: 1'b1});
      @(posedge clk);
      #1;
      in_bus.req[0] = 1'b0;
      @(negedge clk);
      chk("single_req", {31'd0, tcdm_bus.req[0]}, 32'd1);
      chk("single_add", tcdm_bus.add[0], 32'h0000_1000);
      tick();
      tcdm_bus.r_valid[0] = 1'b1;
      tcdm_bus.r_data[0]  = 32'hCAFE_F00D;
      rsp_q[0].push_back(32'hCAFE_F00D);
      @(negedge clk);
      chk("single_rvalid", {31'd0, in_bus.r_valid[0]}, 32'd1);
      tick();
      tcdm_bus.r_valid[0] = 1'b0;

      // Stall: gnt low, FIFO fills after 4 pushes, 10 stall cycles
      do_reset();
      tcdm_bus.gnt[0] = 1'b0;
      for (int k = 0; k < 4; k++) push(0, 1'b0, 32'h2000 + 32'(4 * k), 32'hA000_0000 + 32'(k), 4'h3);
      @(negedge clk);
      chk("full_gnt0", {31'd0, in_bus.gnt[0]}, 32'd0);
      chk("full_gnt1", {31'd0, in_bus.gnt[1]}, 32'd1);
      repeat (7) @(posedge clk);
      #1;
      tcdm_bus.gnt[0] = 1'b1;
      @(negedge clk);
      chk("stall_cnt0", stall[0], EXP_STALL);
      chk("stall_cnt1", stall[1], 32'd0);
      repeat (4) tick();
      @(negedge clk);
      chk("drained_gnt0", {31'd0, in_bus.gnt[0]}, 32'd1);
      chk("stall_hold0", stall[0], EXP_STALL);

      // Outstanding limit: third read held until first response
      tick();
      push(0, 1'b1, 32'h3000, 32'h0, 4'hF);
      push(0, 1'b1, 32'h3004, 32'h0, 4'hF);
      push(0, 1'b1, 32'h3008, 32'h0, 4'hF);
      @(negedge clk);
      chk("third_held_a", {31'd0, tcdm_bus.req[0]}, 32'd0);
      tick();
      tick();
      @(negedge clk);
      chk("third_held_b", {31'd0, tcdm_bus.req[0]}, 32'd0);
      tick();
      tcdm_bus.r_valid[0] = 1'b1;
      tcdm_bus.r_data[0]  = 32'h1111_1111;
      rsp_q[0].push_back(32'h1111_1111);
      @(negedge clk);
      chk("third_held_c", {31'd0, tcdm_bus.req[0]}, 32'd0);
      tick();
      tcdm_bus.r_valid[0] = 1'b0;
      @(negedge clk);
      chk("third_release", {31'd0, tcdm_bus.req[0]}, 32'd1);
      chk("third_add", tcdm_bus.add[0], 32'h3008);
      tick();

      // Write passes while reads are saturated; read budget unchanged
      push(0, 1'b0, 32'h4000, 32'h5555_AAAA, 4'hC);
      @(negedge clk);
      chk("sat_write_req", {31'd0, tcdm_bus.req[0]}, 32'd1);
      chk("sat_write_wen", {31'd0, tcdm_bus.wen[0]}, 32'd0);
      tick();
      push(0, 1'b1, 32'h3010, 32'h0, 4'hF);
      @(negedge clk);
      chk("sat_read_held", {31'd0, tcdm_bus.req[0]}, 32'd1 - 32'd1);
      tick();
      respond(0, 32'h2222_2222);
      respond(0, 32'h3333_3333);
      respond(0, 32'h4444_4444);
      tick();
      @(negedge clk);
      chk("sat_err0", {31'd0, err[0]}, 32'd0);

      // Clear with 3 queued writes and 1 outstanding read
      tick();
      push(0, 1'b1, 32'h5000, 32'h0, 4'hF);
      tick();
      tcdm_bus.gnt[0] = 1'b0;
      push(0, 1'b0, 32'h6000, 32'h1, 4'hF);
      push(0, 1'b0, 32'h6004, 32'h2, 4'hF);
      push(0, 1'b0, 32'h6008, 32'h3, 4'hF);
      clear = 1'b1;
      in_bus.req[0]  = 1'b1;
      in_bus.wen[0]  = 1'b0;
      in_bus.add[0]  = 32'h7000;
      in_bus.data[0] = 32'h7;
      @(negedge clk);
      chk("clear_gnt_low", {31'd0, in_bus.gnt[0]}, 32'd0);
      @(posedge clk);
      #1;
      clear = 1'b0;
      in_bus.req[0] = 1'b0;
      exp_q[0].delete();
      @(negedge clk);
      chk("clear_req_low", {31'd0, tcdm_bus.req[0]}, 32'd0);
      chk("clear_gnt_back", {31'd0, in_bus.gnt[0]}, 32'd1);
      tcdm_bus.gnt[0] = 1'b1;
      tick();
      respond(0, 32'hCAFE_0001);
      tick();
      tick();
      @(negedge clk);
      chk("clear_err0", {31'd0, err[0]}, 32'd0);

      // Spurious response on idle port 1
      tick();
      respond(1, 32'hDEAD_0001);
      @(negedge clk);
      chk("spur_err1", {31'd0, err[1]}, 32'd1);
      chk("spur_err0", {31'd0, err[0]}, 32'd0);
      repeat (3) tick();
      @(negedge clk);
      chk("spur_err1_hold", {31'd0, err[1]}, 32'd1);
      tick();
      do_reset();
      @(negedge clk);
      chk("spur_err_rst", {30'd0, err}, 32'd0);

      // Reset mid-transaction: late response is an underflow
      tick();
      push(0, 1'b1, 32'h8000, 32'h0, 4'hF);
      tick();
      do_reset();
      respond(0, 32'h1234_5678);
      @(negedge clk);
      chk("late_rsp_err0", {31'd0, err[0]}, 32'd1);
      tick();
      do_reset();
      @(negedge clk);
      chk("final_err", {30'd0, err}, 32'd0);

      for (int p = 0; p < MP; p++) begin
         chk($sformatf("exp_q_empty_p%0d", p), 32'(exp_q[p].size()), 32'd0);
         chk($sformatf("rsp_q_empty_p%0d", p), 32'(rsp_q[p].size()), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/smmha_tcdm_bridge.md
SMMHA_TCDM_BRIDGE -- requirements
Module: smmha_tcdm_bridge

Interface
REQ-001 SHALL have parameter MP, default 2: number of TCDM master ports.
REQ-002 SHALL have parameter DEPTH, default 4: request FIFO entries per port, power of two, >=2.
REQ-003 SHALL have parameter MAX_OUTST, default 2: maximum in-flight reads per port, >=1.
REQ-004 clk_i  in  1  single clock; all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 clear_i  in  1  synchronous soft flush of request FIFOs.
REQ-007 in_req/in_wen  in  MP each  engine request; wen=1 read, wen=0 write.
REQ-008 in_add/in_data  in  MPx32 each  engine address/write data.
REQ-009 in_be  in  MPx4  engine byte enables.
REQ-010 in_gnt  out  MP  request accepted into FIFO.
REQ-011 in_r_data/in_r_valid  out  MPx32 / MP  read response to engine.
REQ-012 tcdm_req/tcdm_wen  out  MP each; tcdm_add/tcdm_data  out  MPx32; tcdm_be  out  MPx4.
REQ-013 tcdm_gnt/tcdm_r_valid  in  MP each; tcdm_r_data  in  MPx32.
REQ-014 err_o  out  MP  sticky per-port response-underflow flag.
REQ-015 stall_cnt_o  out  MPx32  per-port TCDM stall counters.

Function
REQ-016 Each port SHALL be independent; no cross-port arbitration or ordering.
REQ-017 in_gnt[i] SHALL be high exactly when FIFO i is not full; a push occurs on in_req&in_gnt.
REQ-018 A pushed request SHALL reach tcdm_req no earlier than the following cycle (no bypass, 1-cycle minimum latency).
REQ-019 tcdm_req[i] SHALL be high when FIFO i is non-empty and (head is a write, or outst[i] < MAX_OUTST); it holds address/data/be/wen stable until tcdm_gnt.
REQ-020 A pop SHALL occur on tcdm_req&tcdm_gnt; push and pop in the same cycle on a full FIFO SHALL be blocked on the push side (gnt low), count unchanged otherwise.
REQ-021 outst[i] SHALL increment on a granted read, decrement on tcdm_r_valid; both in one cycle leave it unchanged.
REQ-022 tcdm_r_valid with outst[i]==0 and no same-cycle granted read SHALL set err_o[i] and leave outst[i] at 0.
REQ-023 in_r_data/in_r_valid SHALL be combinational pass-through of tcdm_r_data/tcdm_r_valid.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; full/empty via an extra pointer MSB.
REQ-025 clear_i SHALL empty all FIFOs next cycle, including a pending ungranted tcdm_req; outst and err_o SHALL NOT be cleared, so pending responses still return.
REQ-026 clear_i SHALL take priority over a simultaneous push (push discarded, in_gnt still low for that cycle).

Reset
REQ-027 rst_i SHALL empty FIFOs, set outst=0, err_o=0, stall_cnt_o=0; tcdm_req=0, in_gnt=1 (all ports) the cycle after release.
REQ-028 Reset mid-transaction SHALL drop in-flight responses; their late r_valid SHALL set err_o.

Configuration
REQ-029 With SMMHA_BRIDGE_PERF_EN defined, stall_cnt_o[i] SHALL count cycles of tcdm_req&!tcdm_gnt, saturating at 0xFFFFFFFF, cleared by rst_i only.
REQ-030 Without SMMHA_BRIDGE_PERF_EN, stall_cnt_o SHALL be tied to 0 and no counter flops synthesised.

Structure
REQ-031 smmha_package SHALL hold the request struct (add, data, be, wen) and defaults for DEPTH and MAX_OUTST.
REQ-032 One sub-module smmha_tcdm_fifo (parametric depth, struct payload, clear input) SHALL be instantiated once per port.

Verification
REQ-033 Single read port0, tcdm_gnt=1: in_req at cycle 0 -> tcdm_req at cycle 1, add=0x1000, r_valid/r_data=0xCAFEF00D passed the cycle it arrives.
REQ-034 tcdm_gnt=0 for 10 cycles, DEPTH=4: in_gnt drops after 4 pushes; stall_cnt_o=10 with PERF_EN, 0 without.
REQ-035 MAX_OUTST=2, r_valid withheld: 3 back-to-back reads -> third held on tcdm_req until first r_valid.
REQ-036 Writes with MAX_OUTST saturated by reads: write at FIFO head still issues; outst unchanged.
REQ-037 clear_i with 3 queued and 1 outstanding read: FIFO empty next cycle, late r_valid passed, err_o stays 0.
REQ-038 Spurious tcdm_r_valid on idle port1: err_o[1]=1 and held until rst_i; port0 unaffected.
